mismatch_monitor: RTL
=====================

Name: mismatch_monitor

Overview:
- Synthesizable scoreboard that observes the far end of a reference-versus-DUT output comparison.
- Each sample compares a reference output vector with a DUT output vector, one field per compared signal.
- Accumulates sample count, total mismatching samples, per-signal mismatch counts and first-mismatch timestamps, then reports pass/fail at end of test.
- Sits beside a constant or stimulus-driven DUT as an on-chip replacement for a simulation-only checker.

Parameters:
- NUM_SIG, 4, number of compared signals (fields).
- SIG_W, 1, width of each signal field in bits.
- CNT_W, 16, width of the sample and mismatch counters.
- TS_W, 32, width of the cycle timestamp counter.

Ports:
- clk  in  1  clock, all state on rising edge.
- areset_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; arms a new test and clears statistics.
- sample_en  in  1  compare ref_vec/dut_vec this cycle.
- end_of_test  in  1  pulse; closes the test.
- ref_vec  in  NUM_SIG*SIG_W  reference outputs; field i at [i*SIG_W +: SIG_W].
- dut_vec  in  NUM_SIG*SIG_W  DUT outputs, same layout as ref_vec.
- care_vec  in  NUM_SIG*SIG_W  per-bit compare mask; 0 = don't-care.
- samples  out  CNT_W  number of samples taken.
- errors  out  CNT_W  number of samples with at least one mismatching signal.
- err_sig_cnt  out  NUM_SIG*CNT_W  per-signal mismatch count.
- first_err_time  out  TS_W  timestamp of the first mismatching sample.
- first_sig_time  out  NUM_SIG*TS_W  per-signal first-mismatch timestamp.
- first_ref  out  NUM_SIG*SIG_W  ref_vec at the first mismatch; see Optional Feature.
- first_dut  out  NUM_SIG*SIG_W  dut_vec at the first mismatch; see Optional Feature.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- pass  out  1  high in DONE when errors==0.

Behaviour:
- Reset: areset_n low clears all outputs and registers to 0 immediately (asynchronous), including pass and done. State becomes IDLE.
- States: IDLE, RUN, DONE.
  - IDLE: start goes to RUN; sample_en and end_of_test are ignored.
  - RUN: end_of_test goes to DONE; start is ignored.
  - DONE: start goes to RUN; sample_en and end_of_test are ignored.
- Entering RUN from start: the same edge clears all statistics and sets ts=0.
- Timestamp: ts increments by 1 every cycle in RUN and saturates at all-ones. It holds its value in IDLE and DONE.
- Mismatch rule, signal i: mismatch when any bit of ((ref ^ dut) & care) in field i is 1.
  - Sample mismatch is the OR over all fields.
- Update on a sample_en edge in RUN:
  - samples increments.
  - errors increments if the sample mismatches.
  - err_sig_cnt[i] increments if field i mismatches.
  - first_err_time and first_sig_time[i] load the current ts only on their first mismatch.
- All counters saturate at 2^CNT_W-1 and never wrap.
- Latency: results are visible 1 cycle after the sampling edge, i.e. registered outputs with no combinational path from inputs.
- Simultaneous events in RUN: sample_en together with end_of_test counts that sample, then enters DONE.
- pass = done & (errors==0). It is registered and asserted on the same cycle as done.
- Reset during RUN aborts the test; no partial result is retained.

Optional Feature:
- Macro: MISMATCH_CAPTURE_EN.
- Defined: on the first mismatching sample of a test, first_ref/first_dut capture ref_vec/dut_vec (unmasked). They hold until start or reset.
- Undefined: the capture registers are not built; first_ref and first_dut are tied to 0.

Decomposition:
- Package mon_pkg holds:
  - enum mon_state_t {IDLE, RUN, DONE};
  - localparam helper for the field slice width;
  - typedef for the counter vector.
- One sub-module: sat_counter (params W; ports clk, areset_n, clr, inc, q). It is instantiated for samples, errors and each err_sig_cnt.

Test Plan:
1. areset_n=0 with no clock edges -> all outputs 0, busy=0, done=0, pass=0.
2. start; 20 samples with ref=4'hF, dut=4'hF, care=4'hF; end_of_test -> samples=20, errors=0, done=1, pass=1.
3. start, then sample every cycle (ts 0..19); dut field 2 wrong at ts=4 and ts=8 -> errors=2, err_sig_cnt[2]=2, others 0, first_err_time=4, first_sig_time[2]=4, pass=0. With MISMATCH_CAPTURE_EN, first_ref=4'hF and first_dut=4'hB.
4. ref=4'h1, dut=4'h0, care=4'hE for 10 samples -> errors=0, samples=10, pass=1.
5. CNT_W=4; 20 mismatching samples on field 0 -> samples=15, errors=15, err_sig_cnt[0]=15 (saturated).
6. Assert areset_n low mid-RUN at sample 7; then start and 3 clean samples -> samples=3, errors=0, no trace of the pre-reset counts.

Source files
------------

// File: rtl/mon_pkg.sv
// Shared state type, counter type and field-slicing helper for mismatch_monitor.
package mon_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} mon_state_t;

    localparam int unsigned DEF_CNT_W = 16;

    typedef logic [DEF_CNT_W-1:0] cnt_t;

    // LSB position of field idx in a vector of w-bit fields.
    function automatic int unsigned field_lsb(int unsigned idx, int unsigned w);
        return idx * w;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         areset_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/mismatch_monitor.sv
// On-chip scoreboard comparing reference and DUT output vectors sample by sample.
// Define MISMATCH_CAPTURE_EN to keep the raw ref/dut vectors of the first failing sample.
module mismatch_monitor
    import mon_pkg::*;
#(
    parameter int unsigned NUM_SIG = 4,
    parameter int unsigned SIG_W   = 1,
    parameter int unsigned CNT_W   = $bits(cnt_t),
    parameter int unsigned TS_W    = 32
) (
    input  logic                     clk,
    input  logic                     areset_n,
    input  logic                     start,
    input  logic                     sample_en,
    input  logic                     end_of_test,
    input  logic [NUM_SIG*SIG_W-1:0] ref_vec,
    input  logic [NUM_SIG*SIG_W-1:0] dut_vec,
    input  logic [NUM_SIG*SIG_W-1:0] care_vec,
    output logic [CNT_W-1:0]         samples,
    output logic [CNT_W-1:0]         errors,
    output logic [NUM_SIG*CNT_W-1:0] err_sig_cnt,
    output logic [TS_W-1:0]          first_err_time,
    output logic [NUM_SIG*TS_W-1:0]  first_sig_time,
    output logic [NUM_SIG*SIG_W-1:0] first_ref,
    output logic [NUM_SIG*SIG_W-1:0] first_dut,
    output logic                     busy,
    output logic                     done,
    output logic                     pass
);

    localparam int unsigned VEC_W = NUM_SIG * SIG_W;

    mon_state_t         state_q, state_d;
    logic [TS_W-1:0]    ts_q, ts_d;
    logic [TS_W-1:0]    err_time_q;
    logic               pass_q, pass_d;
    logic               clr_stats;
    logic               upd;
    logic [VEC_W-1:0]   diff;
    logic [NUM_SIG-1:0] sig_mis;
    logic               samp_mis;
    logic               first_samp_mis;

    assign diff = (ref_vec ^ dut_vec) & care_vec;

    for (genvar i = 0; i < NUM_SIG; i++) begin : g_mis
        assign sig_mis[i] = |diff[field_lsb(i, SIG_W) +: SIG_W];
    end

    assign samp_mis       = |sig_mis;
    // Error count still zero: this mismatch is the first of the current test.
    assign first_samp_mis = upd && samp_mis && (errors == '0);

    always_comb begin
        state_d   = state_q;
        ts_d      = ts_q;
        pass_d    = pass_q;
        clr_stats = 1'b0;
        upd       = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = RUN;
                    ts_d      = '0;
                    pass_d    = 1'b0;
                    clr_stats = 1'b1;
                end
            end
            RUN: begin
                upd = sample_en;
                if (ts_q != '1) begin
                    ts_d = ts_q + TS_W'(1);
                end
                if (end_of_test) begin
                    state_d = DONE;
                    // Include a sample taken on the closing edge in the verdict.
                    pass_d  = (errors == '0) && !(sample_en && samp_mis);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q    <= IDLE;
            ts_q       <= '0;
            pass_q     <= 1'b0;
            err_time_q <= '0;
        end else begin
            state_q <= state_d;
            ts_q    <= ts_d;
            pass_q  <= pass_d;
            if (clr_stats) begin
                err_time_q <= '0;
            end else if (first_samp_mis) begin
                err_time_q <= ts_q;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_samples (
        .clk      (clk),
        .areset_n (areset_n),
        .clr      (clr_stats),
        .inc      (upd),
        .q        (samples)
    );

    sat_counter #(.W(CNT_W)) u_errors (
        .clk      (clk),
        .areset_n (areset_n),
        .clr      (clr_stats),
        .inc      (upd && samp_mis),
        .q        (errors)
    );

    for (genvar i = 0; i < NUM_SIG; i++) begin : g_sig
        logic [CNT_W-1:0] cnt;
        logic [TS_W-1:0]  sig_time_q;

        sat_counter #(.W(CNT_W)) u_cnt (
            .clk      (clk),
            .areset_n (areset_n),
            .clr      (clr_stats),
            .inc      (upd && sig_mis[i]),
            .q        (cnt)
        );

        always_ff @(posedge clk or negedge areset_n) begin
            if (!areset_n) begin
                sig_time_q <= '0;
            end else if (clr_stats) begin
                sig_time_q <= '0;
            end else if (upd && sig_mis[i] && (cnt == '0)) begin
                sig_time_q <= ts_q;
            end
        end

        assign err_sig_cnt[field_lsb(i, CNT_W) +: CNT_W]  = cnt;
        assign first_sig_time[field_lsb(i, TS_W) +: TS_W] = sig_time_q;
    end

`ifdef MISMATCH_CAPTURE_EN
    logic [VEC_W-1:0] first_ref_q, first_dut_q;

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            first_ref_q <= '0;
            first_dut_q <= '0;
        end else if (clr_stats) begin
            first_ref_q <= '0;
            first_dut_q <= '0;
        end else if (first_samp_mis) begin
            first_ref_q <= ref_vec;
            first_dut_q <= dut_vec;
        end
    end

    assign first_ref = first_ref_q;
    assign first_dut = first_dut_q;
`else
    assign first_ref = '0;
    assign first_dut = '0;
`endif

    assign first_err_time = err_time_q;
    assign busy           = (state_q == RUN);
    assign done           = (state_q == DONE);
    assign pass           = pass_q;

endmodule
